demux_1by4_tdm: RTL and testbench
=================================

# demux_1by4_tdm

Time-division demultiplexer that takes one time-multiplexed data lane, as driven by the 2:1/4:1 multiplexer blocks in this library when their select is stepped per slot, and distributes each slot to its own output channel. It locks to a frame-sync marker, captures one sample per enabled slot into a shadow buffer, and publishes a complete frame atomically with a one-cycle valid pulse. It sits on the receive end of a multiplexed link, ahead of per-channel consumer logic.

## Interface
- CHANNELS, 4: slots per frame, ≥2; slot counter width is clog2(CHANNELS).
- WIDTH, 2: bits per slot sample.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  slot strobe; `i` and `fs` are sampled only on edges where en=1.
- fs  input  1  frame sync; high during slot 0 of each frame.
- i  input  WIDTH  multiplexed slot data.
- y  output  CHANNELS*WIDTH  published frame; channel k at y[k*WIDTH +: WIDTH].
- s  output  clog2(CHANNELS)  index of the next slot to be captured.
- v  output  1  one-cycle pulse: y updated with a complete frame.
- lock  output  1  high in LOCK state.
- err  output  1  sticky sync error; cleared only by rst.

## Operation
- State machine: HUNT, LOCK. Internal: shadow buffer sh[0..CHANNELS-1], slot counter `s`.
- rst=1 at an edge: state=HUNT, s=0, y=0, v=0, err=0, lock=0, and sh cleared. rst overrides all other inputs.
- Edge with en=0: state, s, sh, y, and err hold; v=0.
- HUNT, en=1:
  - fs=1: sh[0]<=i, s<=1, go to LOCK.
  - fs=0: sample ignored, stay in HUNT.
- LOCK, en=1, decided in priority order:
  1. fs=1 with s≠0 (early sync): err<=1, partial frame discarded, sh[0]<=i, s<=1, stay in LOCK. y is unchanged and no v.
  2. fs=0 with s=0 (missing sync): err<=1, sample discarded, go to HUNT with s=0. y is unchanged and no v.
  3. Otherwise: sh[s]<=i.
     - If s=CHANNELS-1: y<=concatenation of sh[0..CHANNELS-2] and i (the final slot), v<=1, s<=0.
     - Else: s<=s+1.
- fs=1 with s=0 in LOCK is the normal frame start (case 3).
- Counter wraps from CHANNELS-1 to 0 only through frame completion. s never exceeds CHANNELS-1.
- y changes only on frame completion or rst. Channels never update individually.

## Timing
- Capture latency: y and v update on the same edge that samples slot CHANNELS-1; both are visible in the cycle after that edge.
- v is high for exactly one cycle per completed frame, even if en stays high.
- Back-to-back frames with continuous en give one v every CHANNELS cycles.
- With en duty-cycled, the frame period equals CHANNELS enabled edges; idle cycles are ignored.
- err rises the cycle after the offending edge and stays high until rst.
- lock falls the cycle after a missing-sync edge. It rises the cycle after the first fs=1 edge in HUNT.
- Reset mid-frame: partial frame lost, y=0, and the first frame after reset needs fs again.

## Test plan
All cases use CHANNELS=4, WIDTH=2.
1. **Reset values:** assert rst for 2 cycles with random i, fs, en → y=8'h00, v=0, err=0, lock=0, s=0.
2. **Normal frame:** en=1 continuous, slots i=1,2,3,0 with fs=1 on the first → after the 4th edge y=8'h39 and v high for one cycle. A second frame 3,3,3,3 → y=8'hFF with v again 4 cycles later, and err stays 0.
3. **Enable gaps:** same frame as case 2 with en=0 for 2 cycles between each slot and i toggling while en=0 → y=8'h39; v pulses once, only after the 4th enabled edge.
4. **Early sync:** lock on slots 1,2, then fs=1 with i=2 at s=2, then slots 1,1,1 → err=1, no v at the resync point, then y=8'h56 with v after the 3 further slots.
5. **Missing sync:** complete one frame, then next slot 0 arrives with fs=0 → err=1, lock=0, and y holds. Further slots without fs → no v. Then fs=1 plus 3 slots → frame published.
6. **Reset mid-frame:** rst after 2 slots of a frame → all outputs return to reset values. Remaining slots without fs are ignored.

Source files
------------

// File: rtl/demux_1by4_tdm_if.sv
// Bus bundle for the TDM demultiplexer.
// The master side drives the slot lane (en, fs, i).
// The slave side (the demux) returns the published frame and status:
//   y    - published frame, channel k at y[k*WIDTH +: WIDTH]
//   s    - index of the next slot to be captured
//   v    - one-cycle pulse when y is updated
//   lock - high while locked to frame sync
//   err  - sticky sync error
interface demux_1by4_tdm_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 2
);
    localparam int SW = $clog2(CHANNELS);

    logic                      en;
    logic                      fs;
    logic [WIDTH-1:0]          i;
    logic [CHANNELS*WIDTH-1:0] y;
    logic [SW-1:0]             s;
    logic                      v;
    logic                      lock;
    logic                      err;

    modport master (
        output en, fs, i,
        input  y, s, v, lock, err
    );

    modport slave (
        input  en, fs, i,
        output y, s, v, lock, err
    );
endinterface

// File: rtl/demux_1by4_tdm.sv
// Time-division demultiplexer: locks to frame sync, captures one sample
// per enabled slot into a shadow buffer and publishes the whole frame at
// once with a one-cycle valid pulse.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - demux_1by4_tdm_if.slave (en, fs, i in; y, s, v, lock, err out)
//
// state | meaning
// HUNT  | waiting for fs=1 on an enabled edge
// LOCK  | capturing slots of a frame, s = next slot index
module demux_1by4_tdm #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    demux_1by4_tdm_if.slave     bus
);
    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             s_q, s_d;
    logic [SW-1:0]             cap_idx;
    logic                      cap, pub, set_err;
    logic [WIDTH-1:0]          sh_q [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] y_q, y_d;
    logic                      v_q, err_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cap     = 1'b0;
        cap_idx = '0;
        pub     = 1'b0;
        set_err = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.fs) begin
                        cap     = 1'b1;
                        s_d     = SW'(1);
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.fs && s_q != '0) begin
                        // early sync: drop partial frame, restart at slot 0
                        set_err = 1'b1;
                        cap     = 1'b1;
                        s_d     = SW'(1);
                    end else if (!bus.fs && s_q == '0) begin
                        set_err = 1'b1;
                        s_d     = '0;
                        state_d = HUNT;
                    end else begin
                        cap     = 1'b1;
                        cap_idx = s_q;
                        if (s_q == LAST) begin
                            pub = 1'b1;
                            s_d = '0;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Final slot goes straight from the lane into y, bypassing the buffer.
    always_comb begin
        y_d = '0;
        for (int k = 0; k < CHANNELS - 1; k++) begin
            y_d[k*WIDTH +: WIDTH] = sh_q[k];
        end
        y_d[(CHANNELS-1)*WIDTH +: WIDTH] = bus.i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            s_q     <= '0;
            y_q     <= '0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                sh_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            v_q     <= pub;
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (cap) begin
                sh_q[cap_idx] <= bus.i;
            end
            if (pub) begin
                y_q <= y_d;
            end
        end
    end

    assign bus.y    = y_q;
    assign bus.s    = s_q;
    assign bus.v    = v_q;
    assign bus.lock = (state_q == LOCK);
    assign bus.err  = err_q;
endmodule

// File: tb/tb_demux_1by4_tdm.sv
module tb_demux_1by4_tdm;
    localparam int CH = 4;
    localparam int W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    demux_1by4_tdm_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    demux_1by4_tdm #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of captured samples for the frame in progress.
    bit             m_locked;
    logic [W-1:0]   m_slots[$];
    logic [CH*W-1:0] m_y;
    bit             m_v;
    bit             m_err;

    task automatic model_edge(input bit r, input bit e, input bit f, input logic [W-1:0] d);
        m_v = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_slots.delete();
            m_y   = '0;
            m_err = 1'b0;
        end else if (e) begin
            if (!m_locked) begin
                if (f) begin
                    m_slots.delete();
                    m_slots.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (f && m_slots.size() != 0) begin
                m_err = 1'b1;
                m_slots.delete();
                m_slots.push_back(d);
            end else if (!f && m_slots.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_slots.push_back(d);
                if (m_slots.size() == CH) begin
                    m_y = '0;
                    for (int k = 0; k < CH; k++) m_y[k*W +: W] = m_slots[k];
                    m_v = 1'b1;
                    m_slots.delete();
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge, advance the model, compare at the following negedge.
    task automatic step(input bit r, input bit e, input bit f, input logic [W-1:0] d);
        rst    = r;
        bus.en = e;
        bus.fs = f;
        bus.i  = d;
        @(posedge clk);
        model_edge(r, e, f, d);
        @(negedge clk);
        chk("model_y",    32'(bus.y),    32'(m_y));
        chk("model_v",    32'(bus.v),    32'(m_v));
        chk("model_s",    32'(bus.s),    32'(m_slots.size()));
        chk("model_lock", 32'(bus.lock), 32'(m_locked));
        chk("model_err",  32'(bus.err),  32'(m_err));
    endtask

    typedef struct {
        bit              r, e, f;
        logic [W-1:0]    d;
        logic [CH*W-1:0] y;
        bit              v, lock, err;
        logic [1:0]      s;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit e, bit f, logic [W-1:0] d,
                                logic [CH*W-1:0] y, bit v, bit lk, bit er, logic [1:0] s);
        vec_t t;
        t.r = r; t.e = e; t.f = f; t.d = d;
        t.y = y; t.v = v; t.lock = lk; t.err = er; t.s = s;
        return t;
    endfunction

    initial begin
        bit e, f;
        logic [W-1:0] d;

        bus.en = 1'b0;
        bus.fs = 1'b0;
        bus.i  = '0;

        // reset, normal frames, early sync
        vecs.push_back(mk(1, 1, 1, 2'd3, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 2'd1, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd1, 8'h00, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 2'd2, 8'h00, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 2'd3, 8'h00, 0, 1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 2'd0, 8'h39, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd3, 8'h39, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 2'd3, 8'h39, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 2'd3, 8'h39, 0, 1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 2'd3, 8'hFF, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd1, 8'hFF, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 2'd2, 8'hFF, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 1, 2'd2, 8'hFF, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'hFF, 0, 1, 1, 2));
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'hFF, 0, 1, 1, 3));
        vecs.push_back(mk(0, 1, 0, 2'd1, 8'h56, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 2'd3, 8'h56, 0, 1, 1, 0));

        foreach (vecs[n]) begin
            step(vecs[n].r, vecs[n].e, vecs[n].f, vecs[n].d);
            chk($sformatf("vec%0d_y", n),    32'(bus.y),    32'(vecs[n].y));
            chk($sformatf("vec%0d_v", n),    32'(bus.v),    32'(vecs[n].v));
            chk($sformatf("vec%0d_lock", n), 32'(bus.lock), 32'(vecs[n].lock));
            chk($sformatf("vec%0d_err", n),  32'(bus.err),  32'(vecs[n].err));
            chk($sformatf("vec%0d_s", n),    32'(bus.s),    32'(vecs[n].s));
        end

        // Enable gaps: 2 idle cycles between slots, lane toggling while idle
        step(1, 0, 0, 0);
        for (int k = 0; k < CH; k++) begin
            step(0, 1, k == 0, W'(k + 1));
            chk("gap_v_edge", 32'(bus.v), (k == CH - 1) ? 32'd1 : 32'd0);
            for (int g = 0; g < 2; g++) begin
                step(0, 0, 1'b1, W'(g + 2));
                chk("gap_v_idle", 32'(bus.v), 32'd0);
            end
        end
        chk("gap_y", 32'(bus.y), 32'h39);

        // Missing sync after a complete frame
        step(1, 0, 0, 0);
        for (int k = 0; k < CH; k++) step(0, 1, k == 0, W'(k + 1));
        step(0, 1, 0, 2'd1);
        chk("miss_err",  32'(bus.err),  32'd1);
        chk("miss_lock", 32'(bus.lock), 32'd0);
        chk("miss_y",    32'(bus.y),    32'h39);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 2'd2);
            chk("miss_no_v", 32'(bus.v), 32'd0);
        end
        step(0, 1, 1, 2'd2);
        chk("miss_relock", 32'(bus.lock), 32'd1);
        step(0, 1, 0, 2'd0);
        step(0, 1, 0, 2'd3);
        step(0, 1, 0, 2'd1);
        chk("miss_pub_v", 32'(bus.v), 32'd1);
        chk("miss_pub_y", 32'(bus.y), 32'h72);

        // Reset mid-frame
        step(0, 1, 1, 2'd3);
        step(0, 1, 0, 2'd3);
        step(1, 1, 0, 2'd3);
        chk("rstmid_y",    32'(bus.y),    32'h00);
        chk("rstmid_err",  32'(bus.err),  32'd0);
        chk("rstmid_lock", 32'(bus.lock), 32'd0);
        chk("rstmid_s",    32'(bus.s),    32'd0);
        step(0, 1, 0, 2'd1);
        step(0, 1, 0, 2'd2);
        chk("rstmid_ignored_lock", 32'(bus.lock), 32'd0);
        chk("rstmid_ignored_s",    32'(bus.s),    32'd0);
        chk("rstmid_ignored_v",    32'(bus.v),    32'd0);

        // Randomized traffic: mostly well-formed frames with occasional faults
        step(1, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 3) != 0);
            if (m_slots.size() == 0)
                f = ($urandom_range(0, 9) != 0);
            else
                f = ($urandom_range(0, 19) == 0);
            d = W'($urandom);
            step($urandom_range(0, 149) == 0, e, f, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
